// File: rtl/j_chunk_streamer_if.sv
// Memory request/response and chunk-stream signals of the J chunk streamer.
// master = streamer side, slave = memory + consumer side.
interface j_chunk_streamer_if #(
   parameter int MEM_BANDWIDTH = 4096,
   parameter int ADDR_WIDTH    = 16,
   parameter int IDX_WIDTH     = 6
);
   logic                     mem_req_valid;
   logic [ADDR_WIDTH-1:0]    mem_req_addr;
   logic                     mem_req_ready;
   logic                     mem_rsp_valid;
   logic [MEM_BANDWIDTH-1:0] mem_rsp_data;
   logic                     chunk_valid;
   logic                     chunk_ready;
   logic [MEM_BANDWIDTH-1:0] chunk_data;
   logic [IDX_WIDTH-1:0]     chunk_idx;
   logic                     chunk_last;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
      output chunk_valid, chunk_data, chunk_idx, chunk_last,
      input  chunk_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data,
      input  chunk_valid, chunk_data, chunk_idx, chunk_last,
      output chunk_ready
   );
endinterface

// File: rtl/j_chunk_streamer.sv
// Fetches the J matrix one memory word per request into a credit-limited FIFO
// and streams it out as indexed chunks; supports mid-sweep abort.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing requests while credits allow, streaming chunks
// DRAIN | all requests issued, streaming remaining chunks
// FLUSH | aborted: FIFO cleared, outstanding responses dropped
module j_chunk_streamer #(
   parameter int MEM_BANDWIDTH   = 4096,
   parameter int VECTOR_SIZE     = 256,
   parameter int J_ELEMENT_WIDTH = 4,
   parameter int ADDR_WIDTH      = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   j_chunk_streamer_if.master    bus,
   output logic                  busy,
   output logic                  done,
   output logic                  protocol_err
);
   localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH);
   localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ;
   localparam int IDX_W           = $clog2(NUM_J_CHUNKS);
   localparam int PTR_W           = $clog2(FIFO_DEPTH);
   localparam int CNT_W           = PTR_W + 1;
   localparam int CRED_W          = CNT_W + 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_J_CHUNKS - 1);
   localparam logic [CRED_W-1:0] DEPTH_C  = CRED_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

   state_t                   state;
   logic [ADDR_WIDTH-1:0]    base_q;
   logic [IDX_W-1:0]         req_idx;
   logic [IDX_W-1:0]         out_idx;
   logic [CNT_W-1:0]         outstanding;
   logic [CNT_W-1:0]         fifo_count;
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [MEM_BANDWIDTH-1:0] fifo_mem [FIFO_DEPTH];

   logic              streaming;
   logic              abort_now;
   logic              req_fire;
   logic              rsp_ok;
   logic              push;
   logic              pop;
   logic [CRED_W-1:0] credit_used;
   logic [CNT_W-1:0]  outstanding_nxt;

   assign streaming   = (state == FETCH) || (state == DRAIN);
   assign abort_now   = abort && streaming;
   assign credit_used = CRED_W'(outstanding) + CRED_W'(fifo_count);

   assign bus.mem_req_valid = (state == FETCH) && (credit_used < DEPTH_C);
   assign bus.mem_req_addr  = base_q + ADDR_WIDTH'(req_idx);
   assign bus.chunk_valid   = streaming && (fifo_count != '0);
   assign bus.chunk_data    = bus.chunk_valid ? fifo_mem[rd_ptr] : '0;
   assign bus.chunk_idx     = out_idx;
   assign bus.chunk_last    = (out_idx == LAST_IDX);
   assign busy              = (state != IDLE);

   assign req_fire = bus.mem_req_valid && bus.mem_req_ready;
   // Responses with nothing outstanding are protocol errors and never enter the FIFO.
   assign rsp_ok   = bus.mem_rsp_valid && (outstanding != '0);
   assign push     = rsp_ok && streaming && !abort_now;
   assign pop      = bus.chunk_valid && bus.chunk_ready && !abort_now;

   always_comb begin
      outstanding_nxt = outstanding;
      if (req_fire) outstanding_nxt = outstanding_nxt + CNT_W'(1);
      if (rsp_ok)   outstanding_nxt = outstanding_nxt - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.mem_rsp_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         base_q       <= '0;
         req_idx      <= '0;
         out_idx      <= '0;
         outstanding  <= '0;
         fifo_count   <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         done         <= 1'b0;
         protocol_err <= 1'b0;
      end else begin
         done        <= 1'b0;
         outstanding <= outstanding_nxt;
         if (bus.mem_rsp_valid && (outstanding == '0)) protocol_err <= 1'b1;
         if (req_fire) req_idx <= req_idx + IDX_W'(1);

         if (abort_now || (state == FLUSH)) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
               rd_ptr  <= rd_ptr + PTR_W'(1);
               out_idx <= out_idx + IDX_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
         end

         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state   <= FETCH;
                  base_q  <= base_addr;
                  req_idx <= '0;
                  out_idx <= '0;
               end
            end
            FETCH: begin
               if (abort_now)                          state <= FLUSH;
               else if (req_fire && req_idx == LAST_IDX) state <= DRAIN;
            end
            DRAIN: begin
               if (abort_now) begin
                  state <= FLUSH;
               end else if (pop && bus.chunk_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            FLUSH: begin
               if (outstanding_nxt == '0) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_j_chunk_streamer.sv
// Directed bench for j_chunk_streamer: in-order memory model with per-request
// latency, chunk scoreboard keyed on address, abort/reset/protocol-error cases.
module tb_j_chunk_streamer;
   localparam int MBW = 4096;
   localparam int AW  = 16;
   localparam int IW  = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [AW-1:0] base_addr;
   logic          busy;
   logic          done;
   logic          protocol_err;

   j_chunk_streamer_if #(.MEM_BANDWIDTH(MBW), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) bus ();

   j_chunk_streamer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
      .bus(bus), .busy(busy), .done(done), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc = 0;
   int lat_min, lat_max, rmode, cmode;
   logic [15:0] sweep_base;
   int exp_k, req_cnt, done_cnt, done_cyc, start_cyc, last_due, pend;
   bit flush_mode, force_rsp, rsp_q;
   int unsigned rq_due[$];
   logic [15:0] rq_addr[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [MBW-1:0] mem_word(input logic [15:0] a);
      logic [MBW-1:0] w;
      for (int l = 0; l < MBW/32; l++) w[l*32 +: 32] = {a ^ 16'(l*257), 16'(l) + 16'h5A00};
      return w;
   endfunction

   function automatic logic [31:0] fold(input logic [MBW-1:0] w);
      logic [31:0] f = '0;
      for (int l = 0; l < MBW/32; l++) f ^= w[l*32 +: 32];
      return f;
   endfunction

   function automatic bit pick(input int mode);
      return (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
   endfunction

   task automatic tick();
      logic [MBW-1:0] ew;
      int due;
      @(negedge clk);
      if (flush_mode) begin
         chk("flush_cv", bus.chunk_valid, 0);
         chk("flush_rv", bus.mem_req_valid, 0);
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
         chk("req_addr", bus.mem_req_addr, 16'(sweep_base + 16'(req_cnt)));
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         rq_due.push_back(due);
         rq_addr.push_back(bus.mem_req_addr);
         last_due = due;
         req_cnt++;
      end
      if (bus.mem_rsp_valid && rsp_q) begin
         void'(rq_due.pop_front());
         void'(rq_addr.pop_front());
      end
      if (!flush_mode && bus.chunk_valid && bus.chunk_ready) begin
         ew = mem_word(16'(sweep_base + 16'(exp_k)));
         chk("chunk_idx", bus.chunk_idx, exp_k);
         chk("chunk_last", bus.chunk_last, (exp_k == 63));
         chk("data_lo", bus.chunk_data[63:0], ew[63:0]);
         chk("data_fold", fold(bus.chunk_data), fold(ew));
         exp_k++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      rsp_q = (rq_due.size() > 0) && (rq_due[0] <= cyc);
      bus.mem_rsp_valid = rsp_q || force_rsp;
      bus.mem_rsp_data  = rsp_q ? mem_word(rq_addr[0]) : '0;
      bus.mem_req_ready = pick(rmode);
      bus.chunk_ready   = pick(cmode);
   endtask

   task automatic start_sweep(input logic [15:0] b);
      sweep_base = b;
      exp_k = 0;
      req_cnt = 0;
      done_cnt = 0;
      base_addr = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      base_addr = 16'hDEAD;
      start_cyc = cyc;
   endtask

   task automatic finish_sweep(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk("sweep_chunks", exp_k, 64);
      chk("sweep_reqs", req_cnt, 64);
      chk("sweep_done_once", done_cnt, 1);
      chk("sweep_busy_end", busy, 0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_req_valid"}, bus.mem_req_valid, 0);
      chk({tag, "_req_addr"}, bus.mem_req_addr, 0);
      chk({tag, "_chunk_valid"}, bus.chunk_valid, 0);
      chk({tag, "_chunk_idx"}, bus.chunk_idx, 0);
      chk({tag, "_chunk_last"}, bus.chunk_last, 0);
      chk({tag, "_chunk_data"}, fold(bus.chunk_data), 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_perr"}, protocol_err, 0);
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0;
      bus.mem_req_ready = 1'b0; bus.chunk_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      lat_min = 2; lat_max = 2; rmode = 0; cmode = 0;
      flush_mode = 0; force_rsp = 0; rsp_q = 0; last_due = 0;
      sweep_base = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst = 1'b0;
      tick();

      // T1: full-rate sweep
      start_sweep(16'h0100);
      finish_sweep(200);
      chk("t1_rate", (done_cyc - start_cyc) <= 72, 1);

      // T2: consumer stalled, credits run out
      cmode = 2;
      start_sweep(16'h0400);
      repeat (20) tick();
      chk("t2_reqs", req_cnt, 4);
      chk("t2_req_valid", bus.mem_req_valid, 0);
      chk("t2_chunk_valid", bus.chunk_valid, 1);
      cmode = 0;
      finish_sweep(300);

      // T3: random stalls and latencies
      lat_min = 1; lat_max = 6; rmode = 1; cmode = 1;
      start_sweep(16'h1234);
      finish_sweep(3000);

      // T4: abort mid-sweep
      lat_min = 4; lat_max = 4; rmode = 0; cmode = 0;
      start_sweep(16'h0800);
      n = 0;
      while (exp_k < 10 && n < 200) begin
         tick();
         n++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      pend = rq_due.size();
      flush_mode = 1;
      n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      flush_mode = 0;
      chk("t4_pending_nz", pend != 0, 1);
      chk("t4_busy", busy, 0);
      chk("t4_drained", rq_due.size(), 0);
      chk("t4_no_done", done_cnt, 0);
      chk("t4_perr", protocol_err, 0);
      lat_min = 1; lat_max = 3;
      start_sweep(16'h0800);
      finish_sweep(400);

      // T5: address wrap
      lat_min = 2; lat_max = 2;
      start_sweep(16'hFFF0);
      finish_sweep(200);

      // T6: start ignored while busy, stray response, reset mid-sweep
      lat_min = 3; lat_max = 3;
      start_sweep(16'h0300);
      repeat (5) tick();
      base_addr = 16'h5000;
      start = 1'b1;
      tick();
      start = 1'b0;
      finish_sweep(300);
      chk("t6_perr_clean", protocol_err, 0);
      force_rsp = 1;
      tick();
      force_rsp = 0;
      tick();
      chk("t6_perr_set", protocol_err, 1);
      repeat (5) tick();
      chk("t6_perr_sticky", protocol_err, 1);
      chk("t6_busy_idle", busy, 0);

      start_sweep(16'h0600);
      repeat (8) tick();
      chk("t6_busy_pre_rst", busy, 1);
      rst = 1'b1;
      tick();
      chk_zero_outputs("t6_rst");
      rq_due.delete();
      rq_addr.delete();
      last_due = 0;
      rsp_q = 0;
      bus.mem_rsp_valid = 1'b0;
      rst = 1'b0;
      tick();
      lat_min = 1; lat_max = 4; rmode = 1; cmode = 1;
      start_sweep(16'h0040);
      finish_sweep(2000);
      chk("t6_perr_after", protocol_err, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
